// File: rtl/cart_map_arbiter_pkg.sv
// Shared types and constants for the cartridge mapper arbiter.
package cart_map_pkg;

  // Arbiter phases: normal ownership, waiting for the owner to go idle,
  // and the blanking gap before the new owner is connected.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    BLANK = 2'd2
  } state_e;

  // Channel numbering as seen on sel_idx.
  localparam int CH_DLH  = 0;  // default DSP / LoROM / HiROM mapper
  localparam int CH_CX4  = 1;
  localparam int CH_SDD1 = 2;
  localparam int CH_GSU  = 3;
  localparam int CH_SA1  = 4;

  // Default turbo block mask, bit i = channel i.
  localparam logic [4:0] TURBO_BLOCK_DEF = 5'b01010;

endpackage

// File: rtl/cart_map_arbiter_onehot_dec.sv
// Decodes the map_active request vector into a channel index and flags
// requests that name more than one coprocessor at once.
module cart_map_onehot_dec
  import cart_map_pkg::*;
#(
  parameter int NUM_MAP = 4,
  parameter int IW      = $clog2(NUM_MAP + 1)
) (
  input  logic [NUM_MAP-1:0] map_active,
  output logic [IW-1:0]      target,
  output logic               multi_hot
);

  logic [IW-1:0] last_idx;
  logic          seen;

  // Scan the request bits; a single hit names channel i+1, anything
  // ambiguous falls back to the default channel 0.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch,
    // so no path leaves it holding state and no latch is inferred.
    last_idx  = '0;
    seen      = 1'b0;
    multi_hot = 1'b0;
    for (int i = 0; i < NUM_MAP; i++) begin
      if (map_active[i]) begin
        if (seen) multi_hot = 1'b1;
        seen     = 1'b1;
        last_idx = IW'(i + 1);
      end
    end
    target = multi_hot ? '0 : last_idx;
  end

endmodule

// File: rtl/cart_map_arbiter.sv
// Mapper channel arbiter: routes one of NUM_MAP+1 mapper channels onto
// the shared CPU, ROM and BSRAM ports, and hands ownership over only
// after the current owner has drained and the buses have been blanked.
module cart_map_arbiter
  import cart_map_pkg::*;
#(
  parameter int               NUM_MAP     = 4,
  parameter int               ROM_AW      = 24,
  parameter int               BSRAM_AW    = 20,
  parameter int               SETTLE_CYC  = 4,
  parameter int               DRAIN_MAX   = 64,
  parameter logic [NUM_MAP:0] TURBO_BLOCK = (NUM_MAP + 1)'(TURBO_BLOCK_DEF)
) (
  input  logic                              mclk,
  input  logic                              rst_n,
  input  logic [NUM_MAP-1:0]                map_active,
  input  logic [8*(NUM_MAP+1)-1:0]          ch_do,
  input  logic [NUM_MAP:0]                  ch_irq_n,
  input  logic [ROM_AW*(NUM_MAP+1)-1:0]     ch_rom_addr,
  input  logic [NUM_MAP:0]                  ch_rom_ce_n,
  input  logic [NUM_MAP:0]                  ch_rom_oe_n,
  input  logic [NUM_MAP:0]                  ch_rom_word,
  input  logic [BSRAM_AW*(NUM_MAP+1)-1:0]   ch_bsram_addr,
  input  logic [8*(NUM_MAP+1)-1:0]          ch_bsram_d,
  input  logic [NUM_MAP:0]                  ch_bsram_ce_n,
  input  logic [NUM_MAP:0]                  ch_bsram_oe_n,
  input  logic [NUM_MAP:0]                  ch_bsram_we_n,
  output logic [7:0]                        di,
  output logic                              irq_n,
  output logic [ROM_AW-1:0]                 rom_addr,
  output logic                              rom_ce_n,
  output logic                              rom_oe_n,
  output logic                              rom_word,
  output logic [BSRAM_AW-1:0]               bsram_addr,
  output logic [7:0]                        bsram_d,
  output logic                              bsram_ce_n,
  output logic                              bsram_oe_n,
  output logic                              bsram_we_n,
  output logic [$clog2(NUM_MAP+1)-1:0]      sel_idx,
  output logic                              switching,
  output logic                              conflict,
  output logic                              turbo_allow
);

  localparam int NCH = NUM_MAP + 1;
  localparam int SW  = $clog2(NCH);
  localparam int DCW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(DRAIN_MAX - 1);
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [3:0]       blank_cnt_q, blank_cnt_d;
  logic             conflict_q, conflict_d;
  logic             turbo_q, turbo_d;

  logic [SW-1:0]    target;
  logic             multi_hot;
  logic [SW-1:0]    sel_eff;
  logic             blanking;
  logic             cur_idle;
  logic             cur_turbo_blk;

  logic [7:0]          m_do;
  logic                m_irq_n;
  logic [ROM_AW-1:0]   m_rom_addr;
  logic                m_rom_ce_n, m_rom_oe_n, m_rom_word;
  logic [BSRAM_AW-1:0] m_bsram_addr;
  logic [7:0]          m_bsram_d;
  logic                m_bsram_ce_n, m_bsram_oe_n, m_bsram_we_n;

  cart_map_onehot_dec #(
    .NUM_MAP (NUM_MAP),
    .IW      (SW)
  ) u_dec (
    .map_active (map_active),
    .target     (target),
    .multi_hot  (multi_hot)
  );

  // An index beyond the last channel is never produced; if it ever shows
  // up it is steered to the default channel.
  assign sel_eff  = (sel_q > SW'(NUM_MAP)) ? '0 : sel_q;
  assign blanking = (state_q == BLANK);

  // Per-channel field mux driven by the current owner, plus its turbo mask bit.
  always_comb begin
    m_do          = '0;
    m_irq_n       = 1'b1;
    m_rom_addr    = '0;
    m_rom_ce_n    = 1'b1;
    m_rom_oe_n    = 1'b1;
    m_rom_word    = 1'b0;
    m_bsram_addr  = '0;
    m_bsram_d     = '0;
    m_bsram_ce_n  = 1'b1;
    m_bsram_oe_n  = 1'b1;
    m_bsram_we_n  = 1'b1;
    cur_turbo_blk = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_eff == SW'(i)) begin
        m_do          = ch_do[i*8 +: 8];
        m_irq_n       = ch_irq_n[i];
        m_rom_addr    = ch_rom_addr[i*ROM_AW +: ROM_AW];
        m_rom_ce_n    = ch_rom_ce_n[i];
        m_rom_oe_n    = ch_rom_oe_n[i];
        m_rom_word    = ch_rom_word[i];
        m_bsram_addr  = ch_bsram_addr[i*BSRAM_AW +: BSRAM_AW];
        m_bsram_d     = ch_bsram_d[i*8 +: 8];
        m_bsram_ce_n  = ch_bsram_ce_n[i];
        m_bsram_oe_n  = ch_bsram_oe_n[i];
        m_bsram_we_n  = ch_bsram_we_n[i];
        cur_turbo_blk = TURBO_BLOCK[i];
      end
    end
  end

  // The owner is safe to detach once none of its bus strobes is active.
  assign cur_idle = m_rom_ce_n & m_bsram_ce_n & m_bsram_we_n;

  // Handover sequencing: RUN -> DRAIN (until idle or timeout) -> BLANK
  // (SETTLE_CYC cycles) -> RUN with the re-sampled target.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    drain_cnt_d = drain_cnt_q;
    blank_cnt_d = blank_cnt_q;
    conflict_d  = conflict_q | multi_hot;
    case (state_q)
      RUN: begin
        if (target != sel_eff) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (target == sel_eff) begin
          state_d = RUN;
        end else if (cur_idle || (drain_cnt_q == DRAIN_LAST)) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
        end else if (drain_cnt_q != DRAIN_LAST) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (blank_cnt_q >= SETTLE_LAST) begin
          sel_d   = target;
          state_d = RUN;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        sel_d   = '0;
      end
    endcase
    // Turbo stays off while blanked and for the first cycle after, so the
    // new owner's permission appears one cycle after sel_idx changes.
    if ((state_q == BLANK) || (state_d == BLANK)) turbo_d = 1'b0;
    else                                          turbo_d = ~cur_turbo_blk;
  end

  // State, owner, counters and sticky flags.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      sel_q       <= '0;
      drain_cnt_q <= '0;
      blank_cnt_q <= '0;
      conflict_q  <= 1'b0;
      turbo_q     <= ~TURBO_BLOCK[0];
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      sel_q       <= sel_d;
      drain_cnt_q <= drain_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      conflict_q  <= conflict_d;
      turbo_q     <= turbo_d;
    end
  end

  // Shared-port drive: strobes and CPU-facing signals are parked while
  // blanked, and everything is parked while reset is held.
  always_comb begin
    // NOTE: rst_n is used combinationally here so the ports go quiet the
    // instant reset asserts, not at the next clock edge.
    di         = m_do;
    irq_n      = m_irq_n;
    rom_addr   = m_rom_addr;
    rom_ce_n   = m_rom_ce_n;
    rom_oe_n   = m_rom_oe_n;
    rom_word   = m_rom_word;
    bsram_addr = m_bsram_addr;
    bsram_d    = m_bsram_d;
    bsram_ce_n = m_bsram_ce_n;
    bsram_oe_n = m_bsram_oe_n;
    bsram_we_n = m_bsram_we_n;
    if (!rst_n || blanking) begin
      di         = '0;
      irq_n      = 1'b1;
      rom_ce_n   = 1'b1;
      rom_oe_n   = 1'b1;
      bsram_ce_n = 1'b1;
      bsram_oe_n = 1'b1;
      bsram_we_n = 1'b1;
    end
    if (!rst_n) begin
      rom_addr   = '0;
      rom_word   = 1'b0;
      bsram_addr = '0;
      bsram_d    = '0;
    end
  end

  assign sel_idx     = sel_q;
  assign switching   = (state_q == DRAIN) || (state_q == BLANK);
  assign conflict    = conflict_q;
  assign turbo_allow = turbo_q;

endmodule

// File: tb/tb_cart_map_arbiter.sv
// Scoreboard bench for cart_map_arbiter: a cycle-level reference model
// predicts every port each cycle, a monitor compares at the falling edge.
module tb_cart_map_arbiter;

  localparam int         NM     = 4;
  localparam int         NCH    = NM + 1;
  localparam int         RAW    = 24;
  localparam int         BAW    = 20;
  localparam int         SETTLE = 4;
  localparam int         DMAX   = 64;
  localparam logic [4:0] TBLK   = 5'b01010;

  logic              mclk;
  logic              rst_n;
  logic [NM-1:0]     map_active;
  logic [8*NCH-1:0]  ch_do, ch_bsram_d;
  logic [NCH-1:0]    ch_irq_n, ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
  logic [NCH-1:0]    ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
  logic [RAW*NCH-1:0] ch_rom_addr;
  logic [BAW*NCH-1:0] ch_bsram_addr;
  logic [7:0]        di, bsram_d;
  logic              irq_n, rom_ce_n, rom_oe_n, rom_word;
  logic              bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [RAW-1:0]    rom_addr;
  logic [BAW-1:0]    bsram_addr;
  logic [2:0]        sel_idx;
  logic              switching, conflict, turbo_allow;

  cart_map_arbiter #(
    .NUM_MAP(NM), .ROM_AW(RAW), .BSRAM_AW(BAW),
    .SETTLE_CYC(SETTLE), .DRAIN_MAX(DMAX), .TURBO_BLOCK(TBLK)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n),
    .ch_bsram_we_n(ch_bsram_we_n),
    .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n),
    .rom_oe_n(rom_oe_n), .rom_word(rom_word), .bsram_addr(bsram_addr),
    .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n),
    .bsram_we_n(bsram_we_n), .sel_idx(sel_idx), .switching(switching),
    .conflict(conflict), .turbo_allow(turbo_allow)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic [7:0]     di;
    logic           irq_n;
    logic [RAW-1:0] rom_addr;
    logic           rom_ce_n, rom_oe_n, rom_word;
    logic [BAW-1:0] bsram_addr;
    logic [7:0]     bsram_d;
    logic           bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic [2:0]     sel;
    logic           sw, conf, turbo;
    bit             chk_addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   sw_seen = 0;

  // Reference model: owner, phase (0 owned, 1 waiting for idle, 2 blanked)
  int   m_owner, m_phase, m_waited, m_settle_left;
  bit   m_conf, m_turbo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_phase = 0; m_waited = 0; m_settle_left = 0;
    m_conf = 1'b0; m_turbo = !TBLK[0];
  endtask

  // Predict this cycle's ports from the current inputs, then advance the
  // model across the coming rising edge.
  task automatic model_step();
    exp_t e;
    int   o, ones, want, old_phase;
    bit   idle, blank;
    if (!rst_n) begin
      model_reset();
      e.di = '0; e.irq_n = 1'b1; e.rom_addr = '0; e.rom_ce_n = 1'b1;
      e.rom_oe_n = 1'b1; e.rom_word = 1'b0; e.bsram_addr = '0; e.bsram_d = '0;
      e.bsram_ce_n = 1'b1; e.bsram_oe_n = 1'b1; e.bsram_we_n = 1'b1;
      e.sel = '0; e.sw = 1'b0; e.conf = 1'b0; e.turbo = !TBLK[0]; e.chk_addr = 1'b1;
      sb.push_back(e);
      return;
    end
    o     = m_owner;
    blank = (m_phase == 2);
    e.di         = blank ? 8'h00 : ch_do[o*8 +: 8];
    e.irq_n      = blank ? 1'b1 : ch_irq_n[o];
    e.rom_addr   = ch_rom_addr[o*RAW +: RAW];
    e.rom_ce_n   = blank ? 1'b1 : ch_rom_ce_n[o];
    e.rom_oe_n   = blank ? 1'b1 : ch_rom_oe_n[o];
    e.rom_word   = ch_rom_word[o];
    e.bsram_addr = ch_bsram_addr[o*BAW +: BAW];
    e.bsram_d    = ch_bsram_d[o*8 +: 8];
    e.bsram_ce_n = blank ? 1'b1 : ch_bsram_ce_n[o];
    e.bsram_oe_n = blank ? 1'b1 : ch_bsram_oe_n[o];
    e.bsram_we_n = blank ? 1'b1 : ch_bsram_we_n[o];
    e.sel        = 3'(o);
    e.sw         = (m_phase != 0);
    e.conf       = m_conf;
    e.turbo      = m_turbo;
    e.chk_addr   = !blank;
    sb.push_back(e);

    ones = 0; want = 0;
    for (int i = 0; i < NM; i++) if (map_active[i]) begin ones++; want = i + 1; end
    if (ones > 1) begin want = 0; m_conf = 1'b1; end
    idle = ch_rom_ce_n[o] && ch_bsram_ce_n[o] && ch_bsram_we_n[o];
    old_phase = m_phase;
    if (m_phase == 0) begin
      if (want != o) begin m_phase = 1; m_waited = 0; end
    end else if (m_phase == 1) begin
      if (want == o) m_phase = 0;
      else if (idle || m_waited == DMAX - 1) begin m_phase = 2; m_settle_left = SETTLE; end
      else m_waited++;
    end else begin
      m_settle_left--;
      if (m_settle_left == 0) begin m_owner = want; m_phase = 0; end
    end
    m_turbo = (old_phase == 2 || m_phase == 2) ? 1'b0 : !TBLK[o];
  endtask

  // One clock of stimulus. smode: 0 all strobes idle, 1 ROM strobes held
  // active on every channel, 2 random strobes.
  task automatic cycle(input logic [NM-1:0] map, input bit rst, input int smode);
    @(posedge mclk);
    #1;
    rst_n      = !rst;
    map_active = map;
    for (int i = 0; i < NCH; i++) begin
      ch_do[i*8 +: 8]           = 8'($urandom);
      ch_bsram_d[i*8 +: 8]      = 8'($urandom);
      ch_rom_addr[i*RAW +: RAW] = RAW'($urandom);
      ch_bsram_addr[i*BAW +: BAW] = BAW'($urandom);
      ch_irq_n[i]      = 1'($urandom);
      ch_rom_oe_n[i]   = 1'($urandom);
      ch_rom_word[i]   = 1'($urandom);
      ch_bsram_oe_n[i] = 1'($urandom);
      case (smode)
        0: begin ch_rom_ce_n[i] = 1'b1; ch_bsram_ce_n[i] = 1'b1; ch_bsram_we_n[i] = 1'b1; end
        1: begin ch_rom_ce_n[i] = 1'b0; ch_bsram_ce_n[i] = 1'b1; ch_bsram_we_n[i] = 1'b1; end
        default: begin
          ch_rom_ce_n[i]   = ($urandom_range(0, 3) != 0);
          ch_bsram_ce_n[i] = ($urandom_range(0, 3) != 0);
          ch_bsram_we_n[i] = ($urandom_range(0, 3) != 0);
        end
      endcase
    end
    model_step();
  endtask

  task automatic do_reset();
    cycle('0, 1'b1, 0);
    cycle('0, 1'b1, 0);
    cycle('0, 1'b0, 0);
  endtask

  // Monitor: pop one prediction per cycle and compare every port.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge mclk);
      if (switching === 1'b1) sw_seen++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("di",         32'(di),         32'(e.di));
        check("irq_n",      32'(irq_n),      32'(e.irq_n));
        check("rom_ce_n",   32'(rom_ce_n),   32'(e.rom_ce_n));
        check("rom_oe_n",   32'(rom_oe_n),   32'(e.rom_oe_n));
        check("bsram_ce_n", 32'(bsram_ce_n), 32'(e.bsram_ce_n));
        check("bsram_oe_n", 32'(bsram_oe_n), 32'(e.bsram_oe_n));
        check("bsram_we_n", 32'(bsram_we_n), 32'(e.bsram_we_n));
        check("sel_idx",    32'(sel_idx),    32'(e.sel));
        check("switching",  32'(switching),  32'(e.sw));
        check("conflict",   32'(conflict),   32'(e.conf));
        check("turbo",      32'(turbo_allow), 32'(e.turbo));
        if (e.chk_addr) begin
          check("rom_addr",   32'(rom_addr),   32'(e.rom_addr));
          check("rom_word",   32'(rom_word),   32'(e.rom_word));
          check("bsram_addr", 32'(bsram_addr), 32'(e.bsram_addr));
          check("bsram_d",    32'(bsram_d),    32'(e.bsram_d));
        end
      end
    end
  end

  initial begin : driver
    int         base;
    logic [3:0] map;
    rst_n = 1'b0; map_active = '0; ch_do = '0; ch_bsram_d = '0;
    ch_rom_addr = '0; ch_bsram_addr = '0; ch_irq_n = '1; ch_rom_oe_n = '1;
    ch_rom_word = '0; ch_bsram_oe_n = '1; ch_rom_ce_n = '1;
    ch_bsram_ce_n = '1; ch_bsram_we_n = '1;
    model_reset();

    // Reset and steady ownership of channel 0.
    do_reset();
    repeat (3) cycle('0, 1'b0, 0);

    // Idle owner: one drain cycle then SETTLE blanked cycles, ends on channel 3.
    base = sw_seen;
    repeat (12) cycle(4'b0100, 1'b0, 0);
    @(negedge mclk); #1;
    check("idle_switch_len", 32'(sw_seen - base), 32'(1 + SETTLE));
    check("idle_switch_sel", 32'(sel_idx), 32'd3);

    // Owner busy for 10 cycles after the request: 10 drain + SETTLE blanked.
    do_reset();
    base = sw_seen;
    repeat (10) cycle(4'b1000, 1'b0, 1);
    repeat (10) cycle(4'b1000, 1'b0, 0);
    @(negedge mclk); #1;
    check("busy_switch_len", 32'(sw_seen - base), 32'(10 + SETTLE));
    check("busy_switch_sel", 32'(sel_idx), 32'd4);

    // Owner never idles: forced handover after DMAX drain cycles.
    do_reset();
    base = sw_seen;
    repeat (100) cycle(4'b0001, 1'b0, 1);
    @(negedge mclk); #1;
    check("forced_switch_len", 32'(sw_seen - base), 32'(DMAX + SETTLE));
    check("forced_switch_sel", 32'(sel_idx), 32'd1);

    // Multi-hot request: sticky conflict, owner stays on channel 0.
    do_reset();
    repeat (3) cycle(4'b0011, 1'b0, 2);
    repeat (5) cycle(4'b0000, 1'b0, 2);
    @(negedge mclk); #1;
    check("conflict_sticky", 32'(conflict), 32'd1);
    check("conflict_sel", 32'(sel_idx), 32'd0);
    do_reset();

    // Reset asserted in the middle of blanking.
    repeat (4) cycle(4'b0100, 1'b0, 0);
    cycle(4'b0100, 1'b1, 1);
    cycle('0, 1'b0, 0);
    cycle('0, 1'b0, 0);

    // Randomized traffic with occasional resets.
    map = '0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r >= 17) begin
        r = $urandom_range(0, 3);
        if (r < 2)       map = 4'(1 << $urandom_range(0, 3));
        else if (r == 2) map = '0;
        else             map = 4'($urandom);
      end
      cycle(map, ($urandom_range(0, 299) == 0), 2);
    end

    @(negedge mclk); #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
